wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, LSU buffer entries; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_valid  input  1  ALU result present this cycle.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 alu_stall  output  1  ALU result not accepted this cycle; upstream holds alu_* stable.
REQ-008 lsu_valid  input  1  load/long-latency result offered.
REQ-009 lsu_ready  output  1  LSU offer accepted when lsu_valid && lsu_ready.
REQ-010 lsu_rd  input  5  LSU destination register.
REQ-011 lsu_data  input  32  LSU result.
REQ-012 write_enable  output  1  register-file write strobe; registered.
REQ-013 write_addr  output  5  register-file write address; registered.
REQ-014 write_data  output  32  register-file write data; registered.
REQ-015 fifo_count  output  $clog2(DEPTH)+1  LSU entries buffered.

Function
REQ-016 The block SHALL merge the ALU and LSU result streams onto the single register-file write port, with at most one write per cycle.
REQ-017 The write_* outputs SHALL be registered: a source selected in cycle N produces write_enable=1 in cycle N+1 for exactly one cycle.
REQ-018 A source with rd=0 SHALL be consumed without a write: the ALU is not stalled, an LSU entry is not enqueued, and a buffered rd=0 entry is never created.
REQ-019 lsu_ready SHALL equal (fifo_count < DEPTH), combinationally from state.
REQ-020 Accepted LSU results SHALL be written in acceptance order.
REQ-021 FSM states: NORMAL, DRAIN; reset state NORMAL.
REQ-022 NORMAL, ALU issue: alu_valid, alu_rd!=0 and no hazard -> the ALU result is issued and the LSU path is not issued.
REQ-023 NORMAL, LSU issue: no ALU issue -> the FIFO head is issued if one exists; if the FIFO is empty, an accepted LSU result is issued directly (bypass) and not enqueued.
REQ-024 WAW hazard: alu_valid with alu_rd matching the rd of any buffered entry or of the incoming accepted LSU result -> alu_stall=1, and the FIFO head (or the bypass) is issued instead.
REQ-025 alu_stall SHALL be 1 in DRAIN or on a hazard, and 0 otherwise, including when alu_valid=0.
REQ-026 NORMAL->DRAIN when fifo_count equals DEPTH at the end of a cycle.
REQ-027 DRAIN: the FIFO head is issued every cycle and the ALU is always stalled; enqueue is permitted when lsu_ready=1.
REQ-028 DRAIN->NORMAL when fifo_count becomes 0 at the end of a cycle.
REQ-029 Simultaneous enqueue and dequeue SHALL leave fifo_count unchanged; read and write pointers wrap modulo DEPTH.
REQ-030 Enqueue at full and dequeue at empty SHALL never occur.

Reset
REQ-031 Reset SHALL clear write_enable, write_addr, write_data and fifo_count to 0, set the FSM to NORMAL, and discard buffered entries; it overrides all activity in progress.
REQ-032 During reset: lsu_ready=0 and alu_stall=1.
REQ-033 FIFO data storage need not be cleared.

Configuration
REQ-034 Macro WB_ARBITER_PERF_EN, when defined, SHALL add output alu_stall_cycles (32 bits) counting cycles with alu_valid && alu_stall; the counter saturates at 0xFFFFFFFF and is cleared by reset.
REQ-035 Without WB_ARBITER_PERF_EN, the port and counter SHALL be absent, and all other behaviour is identical.

Verification
REQ-036 ALU only: alu_valid=1, rd=5, data=0x11 -> next cycle write_enable=1, write_addr=5, write_data=0x11; alu_stall=0.
REQ-037 Bypass: FIFO empty, alu_valid=0, lsu rd=7, data=0xAB -> lsu_ready=1, next cycle write of 0xAB to x7, fifo_count stays 0.
REQ-038 Contention: ALU rd=3 and LSU rd=4 in the same cycle -> write x3, then x4 the next cycle; fifo_count 1 then 0.
REQ-039 WAW: x9 is buffered and ALU rd=9 is presented -> alu_stall=1 until the x9 entry is written; the ALU write follows one cycle later.
REQ-040 Drain: DEPTH=4, ALU busy with distinct rd while 4 LSU results are accepted -> DRAIN, lsu_ready=0, 4 consecutive LSU writes in order, then NORMAL with alu_stall=0.
REQ-041 rd=0 and reset: ALU rd=0 produces no write; reset asserted with fifo_count=3 -> next cycle fifo_count=0, write_enable=0, no stale writes afterwards.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges ALU and LSU results, buffering LSU results in a FIFO.
// Optional macro WB_ARBITER_PERF_EN adds the alu_stall_cycles counter output.
module wb_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alu_valid,
   input  logic [4:0]                 alu_rd,
   input  logic [31:0]                alu_data,
   output logic                       alu_stall,
   input  logic                       lsu_valid,
   output logic                       lsu_ready,
   input  logic [4:0]                 lsu_rd,
   input  logic [31:0]                lsu_data,
   output logic                       write_enable,
   output logic [4:0]                 write_addr,
   output logic [31:0]                write_data,
`ifdef WB_ARBITER_PERF_EN
   output logic [31:0]                alu_stall_cycles,
`endif
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} state_t;

   state_t          r_state, w_next_state;
   logic [4:0]      r_mem_rd   [DEPTH];
   logic [31:0]     r_mem_data [DEPTH];
   logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
   logic [CW-1:0]   r_count, w_count_nxt;
   logic            r_we;
   logic [4:0]      r_waddr;
   logic [31:0]     r_wdata;

   logic            w_lsu_ready, w_lsu_acc, w_alu_req, w_buf_match, w_hazard, w_alu_stall;
   logic            w_issue, w_enq, w_deq;
   logic [4:0]      w_issue_rd;
   logic [31:0]     w_issue_data;

   // Only slots between the read pointer and read pointer + count hold live entries.
   always_comb begin
      w_buf_match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] v_off;
         v_off = PW'(i) - r_rd_ptr;
         if ((CW'(v_off) < r_count) && (r_mem_rd[i] == alu_rd))
            w_buf_match = 1'b1;
      end
   end

   always_comb begin
      w_lsu_ready = !reset && (r_count < CW'(DEPTH));
      w_lsu_acc   = lsu_valid && w_lsu_ready && (lsu_rd != 5'd0);
      w_alu_req   = alu_valid && (alu_rd != 5'd0);
      w_hazard    = w_alu_req && (w_buf_match || (w_lsu_acc && (lsu_rd == alu_rd)));
      w_alu_stall = reset || (r_state == DRAIN) || w_hazard;
   end

   always_comb begin
      w_next_state = r_state;
      w_issue      = 1'b0;
      w_issue_rd   = 5'd0;
      w_issue_data = 32'd0;
      w_enq        = 1'b0;
      w_deq        = 1'b0;
      case (r_state)
         NORMAL: begin
            if (w_alu_req && !w_hazard) begin
               w_issue      = 1'b1;
               w_issue_rd   = alu_rd;
               w_issue_data = alu_data;
               w_enq        = w_lsu_acc;
            end else if (r_count != '0) begin
               w_issue      = 1'b1;
               w_issue_rd   = r_mem_rd[r_rd_ptr];
               w_issue_data = r_mem_data[r_rd_ptr];
               w_deq        = 1'b1;
               w_enq        = w_lsu_acc;
            end else if (w_lsu_acc) begin
               w_issue      = 1'b1;
               w_issue_rd   = lsu_rd;
               w_issue_data = lsu_data;
            end
         end
         DRAIN: begin
            if (r_count != '0) begin
               w_issue      = 1'b1;
               w_issue_rd   = r_mem_rd[r_rd_ptr];
               w_issue_data = r_mem_data[r_rd_ptr];
               w_deq        = 1'b1;
            end
            w_enq = w_lsu_acc;
         end
         default: w_next_state = NORMAL;
      endcase
      w_count_nxt = r_count + CW'(w_enq) - CW'(w_deq);
      if (r_state == NORMAL && w_count_nxt == CW'(DEPTH))
         w_next_state = DRAIN;
      else if (r_state == DRAIN && w_count_nxt == '0)
         w_next_state = NORMAL;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= NORMAL;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_we     <= 1'b0;
         r_waddr  <= 5'd0;
         r_wdata  <= 32'd0;
      end else begin
         r_state <= w_next_state;
         r_count <= w_count_nxt;
         r_we    <= w_issue;
         if (w_issue) begin
            r_waddr <= w_issue_rd;
            r_wdata <= w_issue_data;
         end
         if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; liveness is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (!reset && w_enq) begin
         r_mem_rd[r_wr_ptr]   <= lsu_rd;
         r_mem_data[r_wr_ptr] <= lsu_data;
      end
   end

`ifdef WB_ARBITER_PERF_EN
   logic [31:0] r_stall_cycles;
   always_ff @(posedge clk) begin
      if (reset)
         r_stall_cycles <= 32'd0;
      else if (alu_valid && w_alu_stall && r_stall_cycles != 32'hFFFF_FFFF)
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end
   assign alu_stall_cycles = r_stall_cycles;
`endif

   assign alu_stall    = w_alu_stall;
   assign lsu_ready    = w_lsu_ready;
   assign write_enable = r_we;
   assign write_addr   = r_waddr;
   assign write_data   = r_wdata;
   assign fifo_count   = r_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=4): ALU path, bypass, contention, WAW, drain, rd=0, reset.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, lsu_valid;
   logic [4:0]  alu_rd, lsu_rd;
   logic [31:0] alu_data, lsu_data;
   logic        alu_stall, lsu_ready, write_enable;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [2:0]  fifo_count;
`ifdef WB_ARBITER_PERF_EN
   logic [31:0] alu_stall_cycles;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
`ifdef WB_ARBITER_PERF_EN
      .alu_stall_cycles(alu_stall_cycles),
`endif
      .fifo_count(fifo_count)
   );

   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      alu_valid = av; alu_rd = ard; alu_data = ad;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL rst_lsu_ready got %0b want 0", lsu_ready); end
      n_cmp++; if (alu_stall !== 1'b1) begin n_err++; $display("FAIL rst_alu_stall got %0b want 1", alu_stall); end
      tick(); tick();
      n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL rst_we got %0b want 0", write_enable); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", fifo_count); end
      n_cmp++; if (write_addr !== 5'd0 || write_data !== 32'd0) begin n_err++; $display("FAIL rst_wdata got %0d/%h want 0/0", write_addr, write_data); end
      reset = 1'b0;
      #1;
      n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL idle_lsu_ready got %0b want 1", lsu_ready); end
      n_cmp++; if (alu_stall !== 1'b0) begin n_err++; $display("FAIL idle_alu_stall got %0b want 0", alu_stall); end
   endtask

   task automatic test_alu_only();
      drive(1, 5, 32'h11, 0, 0, 0);
      #1;
      n_cmp++; if (alu_stall !== 1'b0) begin n_err++; $display("FAIL alu_stall got %0b want 0", alu_stall); end
      tick();
      n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'h11) begin
         n_err++; $display("FAIL alu_write got we=%0b x%0d=%h want we=1 x5=11", write_enable, write_addr, write_data); end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL alu_single_pulse got %0b want 0", write_enable); end
   endtask

   task automatic test_bypass();
      drive(0, 0, 0, 1, 7, 32'hAB);
      #1;
      n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL byp_ready got %0b want 1", lsu_ready); end
      tick();
      n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd7 || write_data !== 32'hAB) begin
         n_err++; $display("FAIL byp_write got we=%0b x%0d=%h want we=1 x7=ab", write_enable, write_addr, write_data); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL byp_count got %0d want 0", fifo_count); end
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_contention();
      drive(1, 3, 32'h33, 1, 4, 32'h44);
      #1;
      n_cmp++; if (alu_stall !== 1'b0) begin n_err++; $display("FAIL cont_stall got %0b want 0", alu_stall); end
      tick();
      n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd3 || write_data !== 32'h33) begin
         n_err++; $display("FAIL cont_first got we=%0b x%0d=%h want we=1 x3=33", write_enable, write_addr, write_data); end
      n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL cont_count1 got %0d want 1", fifo_count); end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd4 || write_data !== 32'h44) begin
         n_err++; $display("FAIL cont_second got we=%0b x%0d=%h want we=1 x4=44", write_enable, write_addr, write_data); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL cont_count0 got %0d want 0", fifo_count); end
   endtask

   task automatic test_waw();
      drive(1, 2, 32'h22, 1, 9, 32'h99);
      tick();
      n_cmp++; if (write_addr !== 5'd2 || fifo_count !== 3'd1) begin
         n_err++; $display("FAIL waw_setup got x%0d cnt=%0d want x2 cnt=1", write_addr, fifo_count); end
      drive(1, 9, 32'h900, 0, 0, 0);
      #1;
      n_cmp++; if (alu_stall !== 1'b1) begin n_err++; $display("FAIL waw_stall got %0b want 1", alu_stall); end
      tick();
      n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'h99) begin
         n_err++; $display("FAIL waw_lsu_first got we=%0b x%0d=%h want we=1 x9=99", write_enable, write_addr, write_data); end
      n_cmp++; if (alu_stall !== 1'b0) begin n_err++; $display("FAIL waw_release got %0b want 0", alu_stall); end
      tick();
      n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'h900) begin
         n_err++; $display("FAIL waw_alu_after got we=%0b x%0d=%h want we=1 x9=900", write_enable, write_addr, write_data); end
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_drain();
      for (int k = 0; k < 4; k++) begin
         drive(1, 5'(10 + k), 32'hA0 + k, 1, 5'(20 + k), 32'hB0 + k);
         #1;
         n_cmp++; if (alu_stall !== 1'b0 || lsu_ready !== 1'b1) begin
            n_err++; $display("FAIL fill_hs[%0d] got stall=%0b ready=%0b want 0/1", k, alu_stall, lsu_ready); end
         tick();
         n_cmp++; if (write_addr !== 5'(10 + k) || fifo_count !== 3'(k + 1)) begin
            n_err++; $display("FAIL fill[%0d] got x%0d cnt=%0d want x%0d cnt=%0d", k, write_addr, fifo_count, 10 + k, k + 1); end
      end
      drive(1, 14, 32'hAE, 0, 0, 0);
      #1;
      n_cmp++; if (lsu_ready !== 1'b0 || alu_stall !== 1'b1) begin
         n_err++; $display("FAIL drain_entry got ready=%0b stall=%0b want 0/1", lsu_ready, alu_stall); end
      for (int j = 0; j < 4; j++) begin
         tick();
         n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'(20 + j) || write_data !== 32'hB0 + j || fifo_count !== 3'(3 - j)) begin
            n_err++; $display("FAIL drain[%0d] got we=%0b x%0d=%h cnt=%0d want we=1 x%0d=%h cnt=%0d",
                              j, write_enable, write_addr, write_data, fifo_count, 20 + j, 32'hB0 + j, 3 - j); end
         if (j < 3) begin
            n_cmp++; if (alu_stall !== 1'b1) begin n_err++; $display("FAIL drain_stall[%0d] got %0b want 1", j, alu_stall); end
         end
      end
      n_cmp++; if (alu_stall !== 1'b0) begin n_err++; $display("FAIL drain_exit_stall got %0b want 0", alu_stall); end
      tick();
      n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd14 || write_data !== 32'hAE) begin
         n_err++; $display("FAIL drain_alu_resume got we=%0b x%0d=%h want we=1 x14=ae", write_enable, write_addr, write_data); end
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_rd0();
      drive(1, 0, 32'h55, 0, 0, 0);
      #1;
      n_cmp++; if (alu_stall !== 1'b0) begin n_err++; $display("FAIL rd0_alu_stall got %0b want 0", alu_stall); end
      tick();
      n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL rd0_alu_we got %0b want 0", write_enable); end
      drive(0, 0, 0, 1, 0, 32'h66);
      #1;
      n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL rd0_lsu_ready got %0b want 1", lsu_ready); end
      tick();
      n_cmp++; if (write_enable !== 1'b0 || fifo_count !== 3'd0) begin
         n_err++; $display("FAIL rd0_lsu got we=%0b cnt=%0d want 0/0", write_enable, fifo_count); end
      drive(1, 8, 32'h88, 1, 0, 32'h77);
      tick();
      n_cmp++; if (write_addr !== 5'd8 || fifo_count !== 3'd0) begin
         n_err++; $display("FAIL rd0_lsu_with_alu got x%0d cnt=%0d want x8 cnt=0", write_addr, fifo_count); end
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reset_midflight();
      for (int k = 0; k < 3; k++) begin
         drive(1, 5'(1 + k), 32'h10 + k, 1, 5'(24 + k), 32'hC0 + k);
         tick();
      end
      n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL mid_count got %0d want 3", fifo_count); end
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      n_cmp++; if (lsu_ready !== 1'b0 || alu_stall !== 1'b1) begin
         n_err++; $display("FAIL mid_rst_hs got ready=%0b stall=%0b want 0/1", lsu_ready, alu_stall); end
      tick();
      n_cmp++; if (fifo_count !== 3'd0 || write_enable !== 1'b0) begin
         n_err++; $display("FAIL mid_rst got cnt=%0d we=%0b want 0/0", fifo_count, write_enable); end
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++; if (write_enable !== 1'b0 || fifo_count !== 3'd0) begin
            n_err++; $display("FAIL stale[%0d] got we=%0b cnt=%0d want 0/0", k, write_enable, fifo_count); end
      end
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_bypass();
      test_contention();
      test_waw();
      test_drain();
      test_rd0();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
